// File: rtl/rv32_fetch_unit_if.sv
// rv32_fetch_unit_if
//   Bundles every handshake the fetch front end has with the outside world.
//   master : fetch unit side
//            drives the imem request and the decode-facing queue head
//   slave  : environment side
//            memory, redirect source and consumer
//   Signals:
//     imem_req_valid/ready/addr  word read request to instruction memory
//     imem_rsp_valid/data        in-order read data, no backpressure
//     redirect_valid/pc          taken branch/jump PC redirect
//     if_valid/ready/instr/pc    buffered instruction stream to decode
interface rv32_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );
endinterface

// File: rtl/rv32_fetch_unit.sv
// rv32_fetch_unit
//   Instruction fetch front end.
//   - Issues pipelined word reads to a variable-latency instruction memory.
//   - Buffers returned words together with their PCs in a small queue.
//   - Presents the queue head to decode over valid/ready.
//   - PC redirects flush the queue and discard every response still
//     outstanding at the moment of the redirect.
//   Parameters:
//     RESET_PC : PC of the first fetch after reset
//     QDEPTH   : queue entries (power of two, >= 2); also the total number of
//                credits (queued + in-flight)
//   Ports:
//     clk      : rising-edge clock
//     reset    : asynchronous, active-high
//     bus      : rv32_fetch_unit_if.master (imem req/rsp, redirect, if_* stream)
module rv32_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  rv32_fetch_unit_if.master bus
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [31:0]      q_instr [QDEPTH];
  logic [31:0]      q_pc    [QDEPTH];

  logic [CNT_W:0]   used;
  logic             credit_ok;
  logic             req_valid;
  logic             req_fire;
  logic             rsp_fire;
  logic             push;
  logic             pop;
  logic             head_valid;

  // One credit per queue slot; a request may only be issued when a slot is
  // guaranteed for its response, so the queue can never overflow.
  always_comb begin
    used      = {1'b0, count_q} + {1'b0, inflight_q};
    credit_ok = (used < (CNT_W+1)'(QDEPTH));
  end

  // Reset gating keeps the outputs at zero while reset is held, independent
  // of the register values.
  assign req_valid  = !reset && !bus.redirect_valid && credit_ok;
  assign head_valid = !reset && (count_q != '0);

  assign req_fire = req_valid && bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_valid;
  assign push     = rsp_fire && (drop_q == '0) && !bus.redirect_valid;
  assign pop      = head_valid && bus.if_ready && !bus.redirect_valid;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = head_valid;
  assign bus.if_instr       = head_valid ? q_instr[rd_ptr_q] : 32'h0;
  assign bus.if_pc          = head_valid ? q_pc[rd_ptr_q]    : 32'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      resp_pc_d  = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // Whatever is still outstanding after this cycle's response belongs
      // to the old path; the response arriving now is discarded as well.
      inflight_d = inflight_q - CNT_W'(rsp_fire);
      drop_d     = inflight_q - CNT_W'(rsp_fire);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      if (rsp_fire && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage needs no reset: an entry is only visible once count says
  // it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr_q] <= bus.imem_rsp_data;
      q_pc[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // A response with nothing outstanding means the memory broke ordering.
  a_rsp_has_request: assert property (
    @(posedge clk) disable iff (reset) !(bus.imem_rsp_valid && (inflight_q == '0))
  );

endmodule

// File: tb/tb_rv32_fetch_unit.sv
module tb_rv32_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   mem_lat;

  rv32_fetch_unit_if bus();

  rv32_fetch_unit #(
    .RESET_PC (32'h0000_0100),
    .QDEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_1234;
  endfunction

  // Fixed-latency in-order memory: response for a request accepted at the
  // edge ending cycle N is presented during cycle N+mem_lat.
  typedef struct {
    logic [31:0] addr;
    int          cd;
  } pend_t;
  pend_t       pend[$];
  logic        m_acc;
  logic        m_rsp;
  logic [31:0] m_addr;

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      m_acc  = bus.imem_req_valid && bus.imem_req_ready && !reset;
      m_addr = bus.imem_req_addr;
      m_rsp  = bus.imem_rsp_valid;
      #1;
      if (reset) begin
        pend.delete();
        bus.imem_rsp_valid = 1'b0;
      end else begin
        if (m_rsp && pend.size() > 0) void'(pend.pop_front());
        foreach (pend[i]) if (pend[i].cd > 0) pend[i].cd = pend[i].cd - 1;
        if (m_acc) pend.push_back('{m_addr, mem_lat - 1});
        if (pend.size() > 0 && pend[0].cd == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = instr_of(pend[0].addr);
        end else begin
          bus.imem_rsp_valid = 1'b0;
        end
      end
    end
  end

  // Consumer-side log of accepted requests and taken instructions.
  logic [31:0] req_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.imem_req_valid && bus.imem_req_ready) req_log.push_back(bus.imem_req_addr);
      if (bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
        pop_pc.push_back(bus.if_pc);
        pop_ins.push_back(bus.if_instr);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc.delete();
    pop_ins.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int n);
    check({tag, "_popcnt_ge"}, 32'(pop_pc.size() >= n), 32'd1);
    for (int i = 0; i < n && i < pop_pc.size(); i++) begin
      check({tag, "_pc"},    pop_pc[i],  base + 32'(4 * i));
      check({tag, "_instr"}, pop_ins[i], instr_of(base + 32'(4 * i)));
    end
  endtask

  task automatic check_reqs(input string tag, input logic [31:0] base, input int n);
    check({tag, "_reqcnt_ge"}, 32'(req_log.size() >= n), 32'd1);
    for (int i = 0; i < n && i < req_log.size(); i++) begin
      check({tag, "_addr"}, req_log[i], base + 32'(4 * i));
    end
  endtask

  task automatic do_reset(input int lat, input logic ifr);
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.if_ready       = ifr;
    bus.imem_req_ready = 1'b1;
    mem_lat            = lat;
    repeat (2) step();
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    reset              = 1'b1;
    mem_lat            = 1;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b1;

    // Reset values, then 1-cycle memory streaming one instruction per cycle.
    repeat (2) step();
    #1;
    check("rst_if_valid",  {31'h0, bus.if_valid},       32'h0);
    check("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    check("rst_if_instr",  bus.if_instr,                32'h0);
    check("rst_if_pc",     bus.if_pc,                   32'h0);
    check("rst_req_addr",  bus.imem_req_addr,           32'h100);
    reset = 1'b0;
    clear_logs();
    step();
    check("t1_lat_c1_valid", {31'h0, bus.if_valid}, 32'h0);
    step();
    check("t1_lat_c2_valid", {31'h0, bus.if_valid}, 32'h1);
    check("t1_first_pc",     bus.if_pc,             32'h100);
    check("t1_first_instr",  bus.if_instr,          instr_of(32'h100));
    repeat (12) step();
    check("t1_req_count", 32'(req_log.size()), 32'd14);
    check("t1_pop_count", 32'(pop_pc.size()),  32'd12);
    check_reqs("t1", 32'h100, 14);
    check_stream("t1", 32'h100, 12);

    // Consumer stalled: exactly QDEPTH requests, then resume without loss.
    do_reset(1, 1'b0);
    repeat (10) step();
    check("t2_req_count", 32'(req_log.size()),       32'd4);
    check("t2_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    check("t2_if_valid",  {31'h0, bus.if_valid},       32'h1);
    check("t2_head_pc",   bus.if_pc,                   32'h100);
    bus.if_ready = 1'b1;
    repeat (20) step();
    check_reqs("t2", 32'h100, 14);
    check_stream("t2", 32'h100, 14);

    // 3-cycle memory, three requests outstanding, redirect to an unaligned PC.
    do_reset(3, 1'b1);
    repeat (3) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2003;
    #1;
    check("t3_no_req_on_redirect", {31'h0, bus.imem_req_valid}, 32'h0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check("t3_next_addr",  bus.imem_req_addr,           32'h2000);
    check("t3_req_valid",  {31'h0, bus.imem_req_valid}, 32'h1);
    check("t3_if_flushed", {31'h0, bus.if_valid},       32'h0);
    clear_logs();
    repeat (20) step();
    check_reqs("t3", 32'h2000, 8);
    check_stream("t3", 32'h2000, 8);

    // Redirect coinciding with a response and a consumer handshake.
    do_reset(2, 1'b1);
    repeat (8) step();
    check("t4_pre_if_valid", {31'h0, bus.if_valid}, 32'h1);
    clear_logs();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_3000;
    step();
    bus.redirect_valid = 1'b0;
    check("t4_no_pop",   32'(pop_pc.size()),      32'd0);
    check("t4_if_valid", {31'h0, bus.if_valid},   32'h0);
    repeat (15) step();
    check_stream("t4", 32'h3000, 8);

    // PC wrap with a randomly stalling memory request port.
    do_reset(1, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    step();
    bus.redirect_valid = 1'b0;
    clear_logs();
    for (int i = 0; i < 30; i++) begin
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.imem_req_ready = 1'b1;
    repeat (10) step();
    check_reqs("t5", 32'hFFFF_FFF8, 8);
    check_stream("t5", 32'hFFFF_FFF8, 8);

    // Reset with two requests in flight and two entries queued.
    do_reset(3, 1'b0);
    repeat (5) step();
    check("t6_pre_if_valid", {31'h0, bus.if_valid}, 32'h1);
    reset = 1'b1;
    #1;
    check("t6_if_valid",  {31'h0, bus.if_valid},       32'h0);
    check("t6_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    check("t6_if_instr",  bus.if_instr,                32'h0);
    check("t6_if_pc",     bus.if_pc,                   32'h0);
    repeat (2) step();
    reset        = 1'b0;
    bus.if_ready = 1'b1;
    clear_logs();
    #1;
    check("t6_addr_after_reset", bus.imem_req_addr,           32'h100);
    check("t6_req_after_reset",  {31'h0, bus.imem_req_valid}, 32'h1);
    repeat (12) step();
    check_reqs("t6", 32'h100, 6);
    check_stream("t6", 32'h100, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
